// File: rtl/mult_sequencer.sv
// Multi-cycle 32x32 radix-2 shift-add multiplier with HI/LO product registers.
// Signed operands are multiplied as magnitudes and the product is negated at the end.
module mult_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        sgn,
  input  logic [31:0] srca,
  input  logic [31:0] srcb,
  input  logic        hiloreadD,
  input  logic        multstartD,
  input  logic        abort,
  output logic        busy,
  output logic        stall_req,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  logic [63:0] acc_q, acc_d;
  logic        neg_q, neg_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [32:0] sum33;
  logic [63:0] prod;
  logic [31:0] mag_a, mag_b;

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    neg_d   = neg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;

    // Magnitude of 0x80000000 wraps to itself, which is correct as unsigned.
    mag_a = (sgn && srca[31]) ? (~srca + 32'd1) : srca;
    mag_b = (sgn && srcb[31]) ? (~srcb + 32'd1) : srcb;
    sum33 = acc_q[0] ? ({1'b0, acc_q[63:32]} + {1'b0, mcand_q}) : {1'b0, acc_q[63:32]};
    prod  = neg_q ? (~acc_q + 64'd1) : acc_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          mcand_d = mag_a;
          acc_d   = {32'd0, mag_b};
          neg_d   = sgn & (srca[31] ^ srcb[31]);
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          acc_d = {sum33, acc_q[31:1]};
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            state_d = FIX;
          end
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!abort) begin
          hi_d   = prod[63:32];
          lo_d   = prod[31:0];
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      mcand_q <= '0;
      acc_q   <= '0;
      neg_q   <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign stall_req = busy & (hiloreadD | multstartD);
  assign done      = done_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule
